// File: rtl/seq_sub32_if.sv
// seq_sub32_if: start/busy/done handshake and operand/result bus for seq_sub32.
// Optional ovf signal present only when SEQ_SUB_OVF_EN is defined.
interface seq_sub32_if #(
   parameter int unsigned WIDTH = 32
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SEQ_SUB_OVF_EN
   logic             ovf;
`endif

`ifdef SEQ_SUB_OVF_EN
   modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
   modport master (output start, a, b, bin, input busy, done, diff, bout);
   modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif

endinterface

// File: rtl/seq_sub32.sv
// seq_sub32: digit-serial subtractor, diff = a - b - bin, DIGIT bits per cycle,
// LSB digit first, with start/busy/done handshake.
// Optional feature macro: SEQ_SUB_OVF_EN adds a registered signed-overflow flag (ovf).
// WIDTH must be an integer multiple of DIGIT, and WIDTH > DIGIT.
module seq_sub32 #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   seq_sub32_if.slave  bus
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW = DIGIT + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             brw;
   logic [WIDTH-1:0] work;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
`ifdef SEQ_SUB_OVF_EN
   logic             a_msb;
   logic             b_msb;
   logic             ovf_q;
`endif

   logic [DW-1:0]    dig;
   logic [WIDTH-1:0] next_work;
   logic             last;

   // Current digit difference; the working result fills from the top and
   // shifts right, so after N digits digit i sits at offset i*DIGIT.
   always_comb begin
      dig       = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - DW'(brw);
      next_work = {dig[DIGIT-1:0], work[WIDTH-1:DIGIT]};
      last      = (cnt == CW'(N - 1));
   end

   // Handshake FSM and digit datapath; completion keys on the last-digit compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         brw    <= 1'b0;
         work   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf_q  <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  brw    <= bus.bin;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= ST_CALC;
`ifdef SEQ_SUB_OVF_EN
                  a_msb  <= bus.a[WIDTH-1];
                  b_msb  <= bus.b[WIDTH-1];
`endif
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_CALC: begin
               a_q  <= a_q >> DIGIT;
               b_q  <= b_q >> DIGIT;
               brw  <= dig[DIGIT];
               work <= next_work;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  diff_q <= next_work;
                  bout_q <= dig[DIGIT];
`ifdef SEQ_SUB_OVF_EN
                  ovf_q  <= (a_msb != b_msb) && (next_work[WIDTH-1] != a_msb);
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
`ifdef SEQ_SUB_OVF_EN
   assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_sub32.sv
// tb_seq_sub32: scoreboard bench for seq_sub32; expected results are queued
// when an operation is launched and compared when done pulses.
module tb_seq_sub32;

   typedef struct packed {
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
   } exp_t;

   logic clk;
   logic rst;
   int unsigned n_checks = 0;
   int unsigned n_err    = 0;
   exp_t        sb_q[$];
   logic        prev_done = 1'b0;

   seq_sub32_if #(.WIDTH(32)) bus ();

   seq_sub32 #(.WIDTH(32), .DIGIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
      logic [32:0] r;
      exp_t        m;
      r      = {1'b0, a} - {1'b0, b} - 33'(bin);
      m.diff = r[31:0];
      m.bout = r[32];
      m.ovf  = (a[31] != b[31]) && (r[31] != a[31]);
      return m;
   endfunction

   // Scoreboard side: pop and compare whenever done pulses.
   always @(negedge clk) begin
      if (bus.done) begin
         check("done_one_cycle", 64'(prev_done), 64'd0);
         check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("diff", 64'(bus.diff), 64'(e.diff));
            check("bout", 64'(bus.bout), 64'(e.bout));
`ifdef SEQ_SUB_OVF_EN
            check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
         end
      end
      prev_done = bus.done;
   end

   // Launch an operation from a negedge where the DUT is ready; returns one negedge after accept.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic bin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      sb_q.push_back(model(a, b, bin));
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_on_accept", 64'(bus.busy), 64'd1);
   endtask

   // Wait for done, checking latency and busy span; elapsed = negedges already seen since accept.
   task automatic wait_done(input int unsigned elapsed);
      int unsigned cyc;
      int unsigned busy_cnt;
      cyc      = elapsed;
      busy_cnt = elapsed;
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (!bus.done && bus.busy) busy_cnt++;
      end
      check("latency", 64'(cyc), 64'd9);
      check("busy_cycles", 64'(busy_cnt), 64'd8);
      check("busy_at_done", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      bit seen;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_diff", 64'(bus.diff), 64'd0);
      check("rst_bout", 64'(bus.bout), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      start_op(32'h0000_0005, 32'h0000_0002, 1'b0);
      wait_done(1);
      start_op(32'h0000_000F, 32'h0000_FFFF, 1'b0);
      wait_done(1);
      start_op(32'h0000_0008, 32'h0000_0005, 1'b1);
      wait_done(1);
      // Launched on the DONE cycle: back-to-back acceptance.
      start_op(32'h1000_0FFF, 32'h0000_FFFF, 1'b1);
      wait_done(1);

      // Start and operand changes during CALC must not disturb the running op.
      start_op(32'h00F0_0000, 32'h0001_0001, 1'b0);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 32'hFFFF_FFFF;
      bus.b     = 32'h0000_0001;
      bus.bin   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom;
      bus.b     = $urandom;
      wait_done(4);

      // Reset during CALC discards the operation.
      start_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_diff", 64'(bus.diff), 64'd0);
      check("midrst_bout", 64'(bus.bout), 64'd0);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("no_done_after_rst", 64'(seen), 64'd0);

      // Boundaries.
      start_op(32'h1234_5678, 32'h1234_5678, 1'b1);
      wait_done(1);
      start_op(32'h0000_0000, 32'h0000_0000, 1'b0);
      wait_done(1);

      for (int i = 0; i < 4; i++) begin
         start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
         wait_done(1);
      end

`ifdef SEQ_SUB_OVF_EN
      start_op(32'h8000_0000, 32'h0000_0001, 1'b0);
      wait_done(1);
      start_op(32'h0000_0005, 32'h0000_0002, 1'b0);
      wait_done(1);
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
